// File: rtl/btn_pkg.sv
// Shared definitions for the debounced button counter: FSM state encoding
// and default sizing constants.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // 20 ms of stability at a 100 MHz system clock
  localparam int DEFAULT_DB_CYCLES = 2000000;

  localparam int DEFAULT_LED_BIT = 8;

endpackage

// File: rtl/debounce_fsm.sv
// Two-flop synchroniser plus stable-time debounce FSM for one push-button.
// Produces the registered debounced level and a combinational strobe that is
// high on the clock edge where a press is accepted. With AUTO_REPEAT_EN the
// block also reports when the button is being held in the PRESSED state.
module debounce_fsm
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
`ifdef AUTO_REPEAT_EN
  output logic hold_pressed,
`endif
  output logic press_set,
  output logic btn_level
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_level_q, btn_level_d;

  assign s         = sync_q[1];
  assign btn_level = btn_level_q;

  // Shift the raw pin through two flops before anything looks at it
  always_comb begin
    sync_d = {sync_q[0], btn};
  end

  // Next state, stability counter and press strobe; the counter restarts
  // whenever the synchronised level disagrees with the pending transition
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          press_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    btn_level_d = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
  end

`ifdef AUTO_REPEAT_EN
  assign hold_pressed = (state_q == PRESSED) && (state_d == PRESSED);
`endif

  // State, counter, level and synchroniser registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      btn_level_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_level_q <= btn_level_d;
    end
  end

endmodule

// File: rtl/btn_debounce_counter.sv
// Debounced push-button driving a wrapping binary LED counter.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat: after REPEAT_DELAY
// cycles held, extra press pulses are produced every REPEAT_PERIOD cycles.
module btn_debounce_counter
  import btn_pkg::*;
#(
  parameter int LED_bit   = DEFAULT_LED_BIT,
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn,
  output logic               btn_level,
  output logic               press_pulse,
  output logic [LED_bit-1:0] LED
);

  logic               press_set;
  logic               press_pulse_q, press_pulse_d;
  logic [LED_bit-1:0] led_q, led_d;

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY);

  logic             hold_pressed;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_fire;
`endif

  debounce_fsm #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
`ifdef AUTO_REPEAT_EN
    .hold_pressed(hold_pressed),
`endif
    .press_set   (press_set),
    .btn_level   (btn_level)
  );

`ifdef AUTO_REPEAT_EN
  // Hold timer: cleared whenever PRESSED is entered or left, reloaded so
  // that later repeats come one period apart instead of one full delay
  always_comb begin
    rep_fire  = 1'b0;
    rep_cnt_d = '0;
    if (hold_pressed) begin
      if (rep_cnt_q == REP_W'(REPEAT_DELAY - 1)) begin
        rep_fire  = 1'b1;
        rep_cnt_d = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end
  end

  // Hold timer register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`endif

  // Merge press sources into one strobe and advance the LED count on it,
  // rolling over from all-ones back to zero
  always_comb begin
`ifdef AUTO_REPEAT_EN
    press_pulse_d = press_set | rep_fire;
`else
    press_pulse_d = press_set;
`endif
    led_d = led_q;
    if (press_pulse_d) begin
      if (led_q == '1) begin
        led_d = '0;
      end else begin
        led_d = led_q + LED_bit'(1);
      end
    end
  end

  // Output registers so the strobe and count change on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      press_pulse_q <= 1'b0;
      led_q         <= '0;
    end else begin
      press_pulse_q <= press_pulse_d;
      led_q         <= led_d;
    end
  end

  assign press_pulse = press_pulse_q;
  assign LED         = led_q;

endmodule

// File: tb/tb_btn_debounce_counter.sv
// Scoreboard bench for btn_debounce_counter with DB_CYCLES=16, LED_bit=8.
// Expected press pulses (cycle and LED value) are queued by the stimulus and
// checked by an independent monitor. The hold-to-repeat scenario is built in
// only when AUTO_REPEAT_EN is defined.
module tb_btn_debounce_counter;

  localparam int DB = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn = 1'b0;
  logic          btn_level;
  logic          press_pulse;
  logic [LW-1:0] LED;

  typedef struct {
    int         at;
    logic [7:0] led;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_led = 8'h00;
  bit         mon_en = 1'b0;

  btn_debounce_counter #(
    .LED_bit  (LW),
    .DB_CYCLES(DB)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY (64),
    .REPEAT_PERIOD(16)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .btn_level  (btn_level),
    .press_pulse(press_pulse),
    .LED        (LED)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Edge counter: after the k-th rising edge cyc equals k
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic b, input int n);
    btn = b;
    step(n);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expectPulse(input int at);
    exp_led = (exp_led == 8'hFF) ? 8'h00 : exp_led + 8'h01;
    sb_q.push_back('{at, exp_led});
  endtask

  task automatic cleanPress();
    expectPulse(cyc + DB + 3);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 30);
  endtask

  task automatic checkDrained(input string name);
    checkOutput({name, "_pending"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic doReset();
    btn   = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n   = 1'b1;
    exp_led = 8'h00;
  endtask

  // Monitor: every press pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (mon_en && press_pulse !== 1'b0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: got press_pulse=%b LED=%0h expected no pulse (cycle %0d)",
                 press_pulse, LED, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("pulse_cycle", cyc, e.at);
        checkOutput("pulse_led", {24'h0, LED}, {24'h0, e.led});
      end
    end
  end

  initial begin
    // Reset with the button held
    btn   = 1'b1;
    rst_n = 1'b0;
    step(3);
    checkOutput("reset_led", {24'h0, LED}, 0);
    checkOutput("reset_level", {31'h0, btn_level}, 0);
    checkOutput("reset_pulse", {31'h0, press_pulse}, 0);
    mon_en  = 1'b1;
    exp_led = 8'h00;
    rst_n   = 1'b1;
    expectPulse(cyc + DB + 3);
    applyStimulus(1'b1, 30);
    checkOutput("held_level", {31'h0, btn_level}, 1);
    checkOutput("held_led", {24'h0, LED}, 1);
    applyStimulus(1'b0, 30);
    checkOutput("released_level", {31'h0, btn_level}, 0);
    checkDrained("reset_press");

    // Bounce: toggle every 3 cycles, then one clean high/low
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus((i % 2) == 0, 3);
    expectPulse(cyc + DB + 3);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, DB + 2);
    checkOutput("bounce_level_before_fall", {31'h0, btn_level}, 1);
    step(1);
    checkOutput("bounce_level_after_fall", {31'h0, btn_level}, 0);
    applyStimulus(1'b0, 11);
    checkOutput("bounce_led", {24'h0, LED}, 1);
    checkDrained("bounce");

    // Wrap: 256 clean presses from zero
    doReset();
    for (int i = 1; i <= 256; i++) begin
      cleanPress();
      if (i == 255) checkOutput("wrap_255", {24'h0, LED}, 32'hFF);
    end
    checkOutput("wrap_0", {24'h0, LED}, 0);
    checkDrained("wrap");

    // Glitch reject: short highs never produce a press
    applyStimulus(1'b1, 10);
    checkOutput("glitch10_level", {31'h0, btn_level}, 0);
    applyStimulus(1'b0, 30);
    applyStimulus(1'b1, DB - 1);
    applyStimulus(1'b0, 30);
    checkOutput("glitch_led", {24'h0, LED}, 0);
    checkOutput("glitch_level", {31'h0, btn_level}, 0);
    checkDrained("glitch");

    // Mid-operation reset during WAIT_PRESS with LED at 5
    doReset();
    for (int i = 0; i < 5; i++) cleanPress();
    checkOutput("mid_led_before", {24'h0, LED}, 5);
    applyStimulus(1'b1, 11);
    rst_n = 1'b0;
    step(2);
    checkOutput("mid_reset_led", {24'h0, LED}, 0);
    checkOutput("mid_reset_level", {31'h0, btn_level}, 0);
    checkOutput("mid_reset_pulse", {31'h0, press_pulse}, 0);
    rst_n   = 1'b1;
    exp_led = 8'h00;
    applyStimulus(1'b0, 30);
    checkOutput("mid_after_led", {24'h0, LED}, 0);
    cleanPress();
    checkOutput("mid_press_led", {24'h0, LED}, 1);
    checkDrained("mid_reset");

`ifdef AUTO_REPEAT_EN
    // Hold 200 cycles: entry pulse, then +64, +80, +96, ... while held
    begin
      int c0;
      int e;
      doReset();
      c0 = cyc;
      e  = c0 + DB + 3;
      expectPulse(e);
      for (int t = e + 64; t <= c0 + 202; t += 16) expectPulse(t);
      applyStimulus(1'b1, 200);
      applyStimulus(1'b0, 30);
      checkOutput("repeat_led", {24'h0, LED}, 9);
      checkDrained("repeat");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
